// File: rtl/score_pkg.sv
// Shared types and screen constants for the score text box path.
package score_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic {
    SHOW  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

endpackage

// File: rtl/score_rect_gen_flash_ctrl.sv
// Blink controller: after each score event the box alternates visible/hidden
// every FLASH_TOGGLE frames for FLASH_FRAMES frames, then returns to steady show.
module flash_ctrl
  import score_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int FLASH_TOGGLE = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic startOfFrame,
  input  logic scoreEvent,
  output logic visible,
  output logic flashing
);

  localparam int FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int TCW = (FLASH_TOGGLE > 1) ? $clog2(FLASH_TOGGLE) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FLASH_FRAMES - 1);
  localparam logic [TCW-1:0] TOG_LAST   = TCW'(FLASH_TOGGLE - 1);

  flash_state_t   r_state, w_state_nxt;
  logic [FCW-1:0] r_frameCnt, w_frameCnt_nxt;
  logic [TCW-1:0] r_togCnt, w_togCnt_nxt;
  logic           r_vis, w_vis_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= SHOW;
      r_frameCnt <= '0;
      r_togCnt   <= '0;
      r_vis      <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_frameCnt <= w_frameCnt_nxt;
      r_togCnt   <= w_togCnt_nxt;
      r_vis      <= w_vis_nxt;
    end
  end

  // A score event always (re)starts the flash and swallows a coincident frame pulse.
  always_comb begin
    w_state_nxt    = r_state;
    w_frameCnt_nxt = r_frameCnt;
    w_togCnt_nxt   = r_togCnt;
    w_vis_nxt      = r_vis;
    case (r_state)
      SHOW: begin
        if (scoreEvent) begin
          w_state_nxt    = FLASH;
          w_frameCnt_nxt = '0;
          w_togCnt_nxt   = '0;
          w_vis_nxt      = 1'b1;
        end
      end
      FLASH: begin
        if (scoreEvent) begin
          w_frameCnt_nxt = '0;
          w_togCnt_nxt   = '0;
          w_vis_nxt      = 1'b1;
        end else if (startOfFrame) begin
          if (r_frameCnt == FRAME_LAST) begin
            w_state_nxt    = SHOW;
            w_frameCnt_nxt = '0;
            w_togCnt_nxt   = '0;
            w_vis_nxt      = 1'b1;
          end else begin
            w_frameCnt_nxt = r_frameCnt + 1'b1;
            if (r_togCnt == TOG_LAST) begin
              w_togCnt_nxt = '0;
              w_vis_nxt    = ~r_vis;
            end else begin
              w_togCnt_nxt = r_togCnt + 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = SHOW;
    endcase
  end

  assign visible  = (r_state == SHOW) || r_vis;
  assign flashing = (r_state == FLASH);

endmodule

// File: rtl/score_rect_gen.sv
// Score box hit test: registered inside flag and ROM offsets, frame-latched position.
// Define SCORE_RECT_SCALE2X_EN to draw the box at double size with pixel doubling.
module score_rect_gen
  import score_pkg::*;
#(
  parameter int OBJECT_WIDTH_X  = 64,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int FLASH_FRAMES    = 30,
  parameter int FLASH_TOGGLE    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        scoreEvent,
  input  logic        enable,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        flashing
);

`ifdef SCORE_RECT_SCALE2X_EN
  localparam int SCALE_SH = 1;
`else
  localparam int SCALE_SH = 0;
`endif

  localparam logic [11:0] SPAN_X = 12'(OBJECT_WIDTH_X << SCALE_SH);
  localparam logic [11:0] SPAN_Y = 12'(OBJECT_HEIGHT_Y << SCALE_SH);

  coord_t      r_tlX, r_tlY;
  logic        r_inside;
  coord_t      r_offX, r_offY;
  logic        r_flashing;

  logic        w_visible, w_flashing;
  logic [11:0] w_px, w_py, w_left, w_top, w_right, w_bottom;
  logic        w_hit, w_inside;
  coord_t      w_diffX, w_diffY;

  flash_ctrl #(
    .FLASH_FRAMES(FLASH_FRAMES),
    .FLASH_TOGGLE(FLASH_TOGGLE)
  ) u_flash (
    .clk         (clk),
    .reset       (reset),
    .startOfFrame(startOfFrame),
    .scoreEvent  (scoreEvent),
    .visible     (w_visible),
    .flashing    (w_flashing)
  );

  // One extra bit keeps edge + span from wrapping, so boxes past 2047 clip.
  assign w_px     = {1'b0, pixelX};
  assign w_py     = {1'b0, pixelY};
  assign w_left   = {1'b0, r_tlX};
  assign w_top    = {1'b0, r_tlY};
  assign w_right  = w_left + SPAN_X;
  assign w_bottom = w_top + SPAN_Y;

  assign w_hit    = (w_px >= w_left) && (w_px < w_right) &&
                    (w_py >= w_top)  && (w_py < w_bottom);
  assign w_inside = w_hit && w_visible && enable;

  assign w_diffX  = pixelX - r_tlX;
  assign w_diffY  = pixelY - r_tlY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tlX      <= '0;
      r_tlY      <= '0;
      r_inside   <= 1'b0;
      r_offX     <= '0;
      r_offY     <= '0;
      r_flashing <= 1'b0;
    end else begin
      if (startOfFrame) begin
        r_tlX <= topLeftX;
        r_tlY <= topLeftY;
      end
      r_inside   <= w_inside;
      r_offX     <= w_inside ? (w_diffX >> SCALE_SH) : '0;
      r_offY     <= w_inside ? (w_diffY >> SCALE_SH) : '0;
      r_flashing <= w_flashing;
    end
  end

  assign InsideRectangle = r_inside;
  assign offsetX         = r_offX;
  assign offsetY         = r_offY;
  assign flashing        = r_flashing;

endmodule

// File: tb/tb_score_rect_gen.sv
// Randomized and directed bench for score_rect_gen against a frame-level reference model.
module tb_score_rect_gen;

  localparam int W  = 64;
  localparam int H  = 32;
  localparam int FF = 30;
  localparam int FT = 5;
`ifdef SCORE_RECT_SCALE2X_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] pixelX, pixelY, topLeftX, topLeftY;
  logic        startOfFrame, scoreEvent, enable;
  logic        InsideRectangle, flashing;
  logic [10:0] offsetX, offsetY;

  score_rect_gen #(
    .OBJECT_WIDTH_X (W),
    .OBJECT_HEIGHT_Y(H),
    .FLASH_FRAMES   (FF),
    .FLASH_TOGGLE   (FT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .startOfFrame   (startOfFrame),
    .topLeftX       (topLeftX),
    .topLeftY       (topLeftY),
    .scoreEvent     (scoreEvent),
    .enable         (enable),
    .InsideRectangle(InsideRectangle),
    .offsetX        (offsetX),
    .offsetY        (offsetY),
    .flashing       (flashing)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: latched corner, flash on/off and frames elapsed in the flash.
  int m_tlx = 0, m_tly = 0, m_frame = 0;
  bit m_flash = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit m_visible();
    return !m_flash || (((m_frame / FT) % 2) == 0);
  endfunction

  task automatic cycle();
    int px, py, exp_in, exp_ox, exp_oy, exp_fl;
    bit hit;
    px     = int'(pixelX);
    py     = int'(pixelY);
    hit    = (px >= m_tlx) && (px < m_tlx + W * S) && (py >= m_tly) && (py < m_tly + H * S);
    exp_in = (hit && m_visible() && enable) ? 1 : 0;
    exp_ox = (exp_in != 0) ? (px - m_tlx) / S : 0;
    exp_oy = (exp_in != 0) ? (py - m_tly) / S : 0;
    exp_fl = m_flash ? 1 : 0;
    @(posedge clk);
    if (startOfFrame) begin
      m_tlx = int'(topLeftX);
      m_tly = int'(topLeftY);
    end
    if (scoreEvent) begin
      m_flash = 1'b1;
      m_frame = 0;
    end else if (m_flash && startOfFrame) begin
      if (m_frame == FF - 1) begin
        m_flash = 1'b0;
        m_frame = 0;
      end else begin
        m_frame++;
      end
    end
    #1;
    check("inside", 32'(InsideRectangle), 32'(exp_in));
    check("offX", 32'(offsetX), 32'(exp_ox));
    check("offY", 32'(offsetY), 32'(exp_oy));
    check("flashing", 32'(flashing), 32'(exp_fl));
    startOfFrame = 1'b0;
    scoreEvent   = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    cycle();
  endtask

  task automatic inbox();
    pixelX = 11'(m_tlx + int'($urandom_range(0, W * S - 1)));
    pixelY = 11'(m_tly + int'($urandom_range(0, H * S - 1)));
  endtask

  task automatic sof();
    startOfFrame = 1'b1;
    cycle();
  endtask

  // Frame f of a flash (f counts frame pulses since the score event).
  task automatic frame(input int f);
    int exp_v;
    sof();
    inbox();
    cycle();
    inbox();
    cycle();
    exp_v = (f < FF) ? ((((f / FT) % 2) == 0) ? 1 : 0) : 1;
    check("frame_vis", 32'(InsideRectangle), 32'((exp_v != 0) && enable));
    check("frame_fl", 32'(flashing), 32'(f < FF));
  endtask

  initial begin
    reset = 1'b1;
    pixelX = '0; pixelY = '0; topLeftX = '0; topLeftY = '0;
    startOfFrame = 1'b0; scoreEvent = 1'b0; enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in", 32'(InsideRectangle), 0);
    check("rst_ox", 32'(offsetX), 0);
    check("rst_oy", 32'(offsetY), 0);
    check("rst_fl", 32'(flashing), 0);
    reset = 1'b0;

    // Hit test and latency
    topLeftX = 11'd100; topLeftY = 11'd50;
    sof();
`ifdef SCORE_RECT_SCALE2X_EN
    probe(227, 113);
    check("s2_in", 32'(InsideRectangle), 1);
    check("s2_ox", 32'(offsetX), 63);
    check("s2_oy", 32'(offsetY), 31);
    probe(228, 113);
    check("s2_out", 32'(InsideRectangle), 0);
    check("s2_outox", 32'(offsetX), 0);
`else
    probe(100, 60);
    check("t1_in", 32'(InsideRectangle), 1);
    check("t1_ox", 32'(offsetX), 0);
    check("t1_oy", 32'(offsetY), 10);
    probe(163, 60);
    check("t1_ox63", 32'(offsetX), 63);
    probe(164, 60);
    check("t1_out", 32'(InsideRectangle), 0);
    check("t1_outox", 32'(offsetX), 0);
    check("t1_outoy", 32'(offsetY), 0);
`endif
    for (int x = 90; x < 240; x++) probe(x, 60);

    // Position latch
    topLeftX = 11'd200;
    probe(150, 60);
    check("latch_hold", 32'(InsideRectangle), 1);
    probe(99, 60);
    check("latch_left", 32'(InsideRectangle), 0);
    sof();
    probe(150, 60);
    check("latch_old_gone", 32'(InsideRectangle), 0);
    probe(200, 60);
    check("latch_new", 32'(InsideRectangle), 1);
    check("latch_new_ox", 32'(offsetX), 0);
    topLeftX = 11'd100;
    sof();

    // Full flash sequence
    scoreEvent = 1'b1;
    cycle();
    inbox(); cycle();
    for (int f = 1; f <= FF; f++) frame(f);

    // Restart mid-flash at frame 12
    scoreEvent = 1'b1;
    cycle();
    for (int f = 1; f <= 12; f++) frame(f);
    inbox();
    scoreEvent = 1'b1;
    cycle();
    for (int f = 1; f <= FF; f++) frame(f);

    // Score event coincident with a frame pulse; latch still happens
    scoreEvent = 1'b1;
    cycle();
    for (int f = 1; f <= 7; f++) frame(f);
    topLeftX = 11'd120;
    scoreEvent = 1'b1;
    startOfFrame = 1'b1;
    cycle();
    inbox(); cycle();
    check("coinc_vis", 32'(InsideRectangle), 1);
    for (int f = 1; f <= FF; f++) frame(f);

    // Clipping at the right edge of the coordinate space
    topLeftX = 11'd2040; topLeftY = 11'd0;
    sof();
    for (int x = 2030; x < 2048; x++) probe(x, 5);
    probe(2047, 5);
    check("clip_in", 32'(InsideRectangle), 1);
    check("clip_ox", 32'(offsetX), 32'(7 / S));
    for (int x = 0; x < 12; x++) probe(x, 5);
    probe(0, 5);
    check("clip_nowrap", 32'(InsideRectangle), 0);

    // Enable low: box hidden while the flash keeps counting
    topLeftX = 11'd100; topLeftY = 11'd50;
    sof();
    scoreEvent = 1'b1;
    cycle();
    enable = 1'b0;
    for (int f = 1; f <= 12; f++) frame(f);
    enable = 1'b1;
    for (int f = 13; f <= 17; f++) frame(f);

    // Reset asserted mid-flash
    inbox(); cycle();
    #2;
    reset = 1'b1;
    #1;
    check("arst_in", 32'(InsideRectangle), 0);
    check("arst_ox", 32'(offsetX), 0);
    check("arst_oy", 32'(offsetY), 0);
    check("arst_fl", 32'(flashing), 0);
    m_flash = 1'b0; m_frame = 0; m_tlx = 0; m_tly = 0;
    @(negedge clk);
    reset = 1'b0;
    probe(10, 10);
    check("arst_show", 32'(InsideRectangle), 1);
    probe(10, 10);
    check("arst_fl2", 32'(flashing), 0);

    // Randomized traffic
    topLeftX = 11'd300; topLeftY = 11'd200;
    sof();
    for (int i = 0; i < 4000; i++) begin
      int px, py;
      px = m_tlx - 10 + int'($urandom_range(0, W * S + 20));
      py = m_tly - 10 + int'($urandom_range(0, H * S + 20));
      if (px < 0) px = 0;
      if (px > 2047) px = 2047;
      if (py < 0) py = 0;
      if (py > 2047) py = 2047;
      pixelX = 11'(px);
      pixelY = 11'(py);
      startOfFrame = ($urandom_range(0, 24) == 0);
      scoreEvent   = ($urandom_range(0, 89) == 0);
      enable       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 7) == 0) topLeftX = 11'($urandom_range(1980, 2047));
        else topLeftX = 11'($urandom_range(0, 700));
        topLeftY = 11'($urandom_range(0, 500));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
